// File: rtl/uart_rx_bcd_frame.sv
// uart_rx_bcd_frame
// 16x-oversampled UART receiver feeding a 4-digit BCD display field.
// Also provides a received-byte strobe and a retriggerable activity LED.
// Default frame is 8N1.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
// With that macro defined, a parity mismatch is reported on o_rx_err and the byte is discarded.
module uart_rx_bcd_frame #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int OVS    = 16,
    parameter int LED_MS = 50
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_data,
    output logic [7:0]  o_rx_byte,
    output logic        o_rx_valid,
    output logic        o_rx_err,
    output logic [15:0] o_bcd4d,
    output logic        o_led_rx
);

    // The tick divider is rounded to the nearest integer and is never allowed below 1.
    localparam int DIV_RAW = (CLK_HZ + (BAUD * OVS) / 2) / (BAUD * OVS);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_M1 = DIV_W'(DIV - 1);

    // The LED hold count is computed in 64 bits because LED_MS * CLK_HZ can exceed 32 bits.
    localparam longint LED_RELOAD_L = (longint'(LED_MS) * longint'(CLK_HZ)) / 64'sd1000 - 64'sd1;
    localparam int     LED_W        = (LED_RELOAD_L > 0) ? $clog2(LED_RELOAD_L + 1) : 1;
    localparam logic [LED_W-1:0] LED_RELOAD = LED_W'(LED_RELOAD_L);

    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             rx_meta;
    logic             rx_s;
    logic [TW-1:0]    tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic [LED_W-1:0] led_timer;
    logic             parity_ok;

    assign tick     = (div_cnt == DIV_M1);
    assign o_led_rx = (led_timer != '0);

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    // Even parity holds when the data bits and the parity bit together contain an even number of ones.
    assign parity_ok = ~(^{shift, par_bit});
`else
    assign parity_ok = 1'b1;
`endif

    // This free-running divider produces one oversample tick every DIV clocks.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_M1) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // This two-flop synchroniser resets high so that reset does not look like a start edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx_data;
            rx_s    <= rx_meta;
        end
    end

    // This block holds the frame FSM, the output strobes, the display loader and the LED hold timer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            o_rx_byte  <= '0;
            o_rx_valid <= 1'b0;
            o_rx_err   <= 1'b0;
            o_bcd4d    <= '0;
            led_timer  <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            o_rx_valid <= 1'b0;
            o_rx_err   <= 1'b0;
            if (led_timer != '0) begin
                led_timer <= led_timer - 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state    <= S_START;
                        tick_cnt <= '0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (tick_cnt == HALF_M1) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= rx_s ? S_IDLE : S_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt <= '0;
                            shift    <= {rx_s, shift[7:1]};
                            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt <= '0;
                            par_bit  <= rx_s;
                            state    <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        if (tick_cnt == FULL_M1) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                o_rx_err <= 1'b1;
                                state    <= S_BREAK;
                            end else if (!parity_ok) begin
                                o_rx_err <= 1'b1;
                                state    <= S_IDLE;
                            end else begin
                                state      <= S_IDLE;
                                o_rx_byte  <= shift;
                                o_rx_valid <= 1'b1;
                                led_timer  <= LED_RELOAD;
                                if (shift >= 8'h30 && shift <= 8'h39) begin
                                    o_bcd4d <= {o_bcd4d[11:0], shift[3:0]};
                                end else if (shift == 8'h43 || shift == 8'h63) begin
                                    o_bcd4d <= '0;
                                end else if (shift == 8'h08) begin
                                    o_bcd4d <= {4'h0, o_bcd4d[15:4]};
                                end
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_bcd_frame.sv
// tb_uart_rx_bcd_frame
// This bench drives UART frames at nominal, fast and slow line rates into uart_rx_bcd_frame.
// A digit-value model predicts the display contents.
// Define UART_RX_PARITY_EN to build and exercise the 8E1 variant.
`timescale 1ps/1ps
module tb_uart_rx_bcd_frame;

    localparam int CLK_HZ   = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int OVS      = 16;
    localparam int LED_MS   = 1;
    localparam int CLK_HALF = 312_500;
    localparam int BIT_NOM  = 10_000_000;
    localparam int BIT_FAST = 9_708_738;
    localparam int BIT_SLOW = 10_309_278;
    localparam int LED_HOLD = LED_MS * CLK_HZ / 1000 - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [7:0]  o_rx_byte;
    logic        o_rx_valid;
    logic        o_rx_err;
    logic [15:0] o_bcd4d;
    logic        o_led_rx;

    int checks = 0;
    int errors = 0;

    int         cyc            = 0;
    int         valid_cnt      = 0;
    int         err_cnt        = 0;
    int         last_valid_cyc = 0;
    int         led_fall_cyc   = -1;
    logic       led_prev       = 1'b0;
    logic [7:0] rx_q[$];

    int         model_val  = 0;
    logic [7:0] model_byte = 8'h00;

    uart_rx_bcd_frame #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD),
        .OVS   (OVS),
        .LED_MS(LED_MS)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_rx_data (rx),
        .o_rx_byte (o_rx_byte),
        .o_rx_valid(o_rx_valid),
        .o_rx_err  (o_rx_err),
        .o_bcd4d   (o_bcd4d),
        .o_led_rx  (o_led_rx)
    );

    always #CLK_HALF clk = ~clk;

    // The monitor samples on the falling edge, logging every strobe and the LED falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (o_rx_valid === 1'b1) begin
            rx_q.push_back(o_rx_byte);
            valid_cnt      = valid_cnt + 1;
            last_valid_cyc = cyc;
        end
        if (o_rx_err === 1'b1) begin
            err_cnt = err_cnt + 1;
        end
        if (led_prev === 1'b1 && o_led_rx === 1'b0) begin
            led_fall_cyc = cyc;
        end
        led_prev = o_led_rx;
    end

    // The model keeps the display as a number 0..9999, so each rule is plain decimal arithmetic.
    function automatic void model_apply(input logic [7:0] b);
        model_byte = b;
        if (b >= 8'h30 && b <= 8'h39) begin
            model_val = (model_val * 10 + (int'(b) - 48)) % 10000;
        end else if (b == 8'h43 || b == 8'h63) begin
            model_val = 0;
        end else if (b == 8'h08) begin
            model_val = model_val / 10;
        end
    endfunction

    function automatic logic [15:0] model_bcd();
        int v;
        v = model_val;
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic send_frame(input logic [7:0] b, input int bit_ps, input logic stop_lvl,
                              input logic par_flip);
        rx = 1'b0;
        #(bit_ps);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ps);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        #(bit_ps);
`else
        if (par_flip) begin
            rx = 1'b1;
        end
`endif
        rx = stop_lvl;
        #(bit_ps);
    endtask

    task automatic send_good(input logic [7:0] b, input int bit_ps);
        send_frame(b, bit_ps, 1'b1, 1'b0);
        model_apply(b);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (o_rx_byte !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_byte got %h want 00", o_rx_byte);
        end
        checks++;
        if (o_rx_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid got %b want 0", o_rx_valid);
        end
        checks++;
        if (o_rx_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_err got %b want 0", o_rx_err);
        end
        checks++;
        if (o_bcd4d !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_bcd got %h want 0000", o_bcd4d);
        end
        checks++;
        if (o_led_rx !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_led got %b want 0", o_led_rx);
        end
        @(negedge clk);
        rst = 1'b0;
        #(2 * BIT_NOM);
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = valid_cnt;
        send_good(8'h31, BIT_NOM);
        send_good(8'h32, BIT_NOM);
        send_good(8'h33, BIT_NOM);
        send_good(8'h34, BIT_NOM);
        #(2 * BIT_NOM);
        checks++;
        if (valid_cnt - v0 !== 4) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d want 4", valid_cnt - v0);
        end
        checks++;
        if (o_rx_byte !== 8'h34) begin
            errors++;
            $display("[TB] FAIL b2b_byte got %h want 34", o_rx_byte);
        end
        checks++;
        if (o_bcd4d !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL b2b_bcd got %h want 1234", o_bcd4d);
        end
        checks++;
        if (o_led_rx !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_led got %b want 1", o_led_rx);
        end
    endtask

    task automatic test_edit();
        int v0;
        send_good(8'h35, BIT_NOM);
        #(BIT_NOM);
        checks++;
        if (o_bcd4d !== 16'h2345) begin
            errors++;
            $display("[TB] FAIL edit_digit got %h want 2345", o_bcd4d);
        end
        send_good(8'h08, BIT_NOM);
        #(BIT_NOM);
        checks++;
        if (o_bcd4d !== 16'h0234) begin
            errors++;
            $display("[TB] FAIL edit_backspace got %h want 0234", o_bcd4d);
        end
        send_good(8'h63, BIT_NOM);
        #(BIT_NOM);
        checks++;
        if (o_bcd4d !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL edit_clear got %h want 0000", o_bcd4d);
        end
        v0 = valid_cnt;
        send_good(8'h41, BIT_NOM);
        #(BIT_NOM);
        checks++;
        if (valid_cnt - v0 !== 1) begin
            errors++;
            $display("[TB] FAIL edit_other_valid got %0d want 1", valid_cnt - v0);
        end
        checks++;
        if (o_rx_byte !== 8'h41) begin
            errors++;
            $display("[TB] FAIL edit_other_byte got %h want 41", o_rx_byte);
        end
        checks++;
        if (o_bcd4d !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL edit_other_bcd got %h want 0000", o_bcd4d);
        end
    endtask

    task automatic test_framing_error();
        int v0;
        int e0;
        logic [7:0] b0;
        v0 = valid_cnt;
        e0 = err_cnt;
        b0 = o_rx_byte;
        send_frame(8'h55, BIT_NOM, 1'b0, 1'b0);
        #(40 * BIT_NOM);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("[TB] FAIL frame_err_count got %0d want 1", err_cnt - e0);
        end
        checks++;
        if (valid_cnt !== v0) begin
            errors++;
            $display("[TB] FAIL frame_no_valid got %0d want %0d", valid_cnt, v0);
        end
        checks++;
        if (o_rx_byte !== b0) begin
            errors++;
            $display("[TB] FAIL frame_byte_held got %h want %h", o_rx_byte, b0);
        end
        checks++;
        if (o_bcd4d !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL frame_bcd_held got %h want 0000", o_bcd4d);
        end
        rx = 1'b1;
        #(2 * BIT_NOM);
        send_good(8'h37, BIT_NOM);
        #(2 * BIT_NOM);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("[TB] FAIL break_single_err got %0d want 1", err_cnt - e0);
        end
        checks++;
        if (o_bcd4d !== 16'h0007) begin
            errors++;
            $display("[TB] FAIL break_then_digit got %h want 0007", o_bcd4d);
        end
    endtask

    task automatic test_glitch();
        int v0;
        int e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        #(2 * BIT_NOM);
        checks++;
        if (valid_cnt !== v0) begin
            errors++;
            $display("[TB] FAIL glitch_no_valid got %0d want %0d", valid_cnt, v0);
        end
        checks++;
        if (err_cnt !== e0) begin
            errors++;
            $display("[TB] FAIL glitch_no_err got %0d want %0d", err_cnt, e0);
        end
        send_good(8'h39, BIT_NOM);
        #(2 * BIT_NOM);
        checks++;
        if (o_rx_byte !== 8'h39) begin
            errors++;
            $display("[TB] FAIL glitch_next_byte got %h want 39", o_rx_byte);
        end
        checks++;
        if (o_bcd4d !== 16'h0079) begin
            errors++;
            $display("[TB] FAIL glitch_next_bcd got %h want 0079", o_bcd4d);
        end
    endtask

    task automatic test_reset_midframe();
        int v0;
        int e0;
        logic [7:0] b;
        b  = 8'h38;
        v0 = valid_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        #(BIT_NOM);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            #(BIT_NOM);
        end
        rx = b[4];
        #(BIT_NOM / 2);
        rst = 1'b1;
        #1000;
        checks++;
        if ({o_rx_byte, o_rx_valid, o_rx_err, o_bcd4d, o_led_rx} !== 27'd0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs got byte=%h v=%b e=%b bcd=%h led=%b want all 0",
                     o_rx_byte, o_rx_valid, o_rx_err, o_bcd4d, o_led_rx);
        end
        model_val  = 0;
        model_byte = 8'h00;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #(2 * BIT_NOM);
        checks++;
        if (valid_cnt !== v0 || err_cnt !== e0) begin
            errors++;
            $display("[TB] FAIL midreset_no_strobe got v=%0d e=%0d want v=%0d e=%0d",
                     valid_cnt, err_cnt, v0, e0);
        end
        send_good(8'h36, BIT_NOM);
        #(2 * BIT_NOM);
        checks++;
        if (o_bcd4d !== 16'h0006) begin
            errors++;
            $display("[TB] FAIL midreset_next_bcd got %h want 0006", o_bcd4d);
        end
        checks++;
        if (o_rx_byte !== 8'h36) begin
            errors++;
            $display("[TB] FAIL midreset_next_byte got %h want 36", o_rx_byte);
        end
    endtask

    task automatic test_baud_tolerance();
        int rates[2];
        logic [7:0] got;
        rates[0] = BIT_FAST;
        rates[1] = BIT_SLOW;
        for (int r = 0; r < 2; r++) begin
            rx_q.delete();
            led_fall_cyc = -1;
            for (int i = 0; i < 10; i++) begin
                send_good(8'(8'h30 + i), rates[r]);
                #(2 * rates[r]);
            end
            checks++;
            if (rx_q.size() !== 10) begin
                errors++;
                $display("[TB] FAIL baud%0d_count got %0d want 10", r, rx_q.size());
            end
            for (int i = 0; i < 10; i++) begin
                got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
                checks++;
                if (got !== 8'(8'h30 + i)) begin
                    errors++;
                    $display("[TB] FAIL baud%0d_byte%0d got %h want %h", r, i, got, 8'(8'h30 + i));
                end
            end
            checks++;
            if (o_bcd4d !== model_bcd()) begin
                errors++;
                $display("[TB] FAIL baud%0d_bcd got %h want %h", r, o_bcd4d, model_bcd());
            end
        end
        repeat (LED_HOLD + 400) @(negedge clk);
        checks++;
        if (o_led_rx !== 1'b0) begin
            errors++;
            $display("[TB] FAIL led_off got %b want 0", o_led_rx);
        end
        checks++;
        if (led_fall_cyc - last_valid_cyc !== LED_HOLD) begin
            errors++;
            $display("[TB] FAIL led_hold got %0d want %0d", led_fall_cyc - last_valid_cyc, LED_HOLD);
        end
    endtask

    task automatic test_random();
        logic [7:0] sent[$];
        logic [7:0] b;
        logic [7:0] got;
        int sel;
        rx_q.delete();
        for (int n = 0; n < 24; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 5) begin
                b = 8'(8'h30 + $urandom_range(0, 9));
            end else if (sel == 6) begin
                b = 8'h43;
            end else if (sel == 7) begin
                b = 8'h63;
            end else if (sel == 8) begin
                b = 8'h08;
            end else begin
                b = 8'($urandom_range(0, 255));
            end
            sent.push_back(b);
            send_good(b, BIT_NOM);
            #(int'($urandom_range(0, 2)) * BIT_NOM);
        end
        #(2 * BIT_NOM);
        checks++;
        if (rx_q.size() !== sent.size()) begin
            errors++;
            $display("[TB] FAIL rand_count got %0d want %0d", rx_q.size(), sent.size());
        end
        for (int i = 0; i < sent.size(); i++) begin
            got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            checks++;
            if (got !== sent[i]) begin
                errors++;
                $display("[TB] FAIL rand_byte%0d got %h want %h", i, got, sent[i]);
            end
        end
        checks++;
        if (o_rx_byte !== model_byte) begin
            errors++;
            $display("[TB] FAIL rand_last_byte got %h want %h", o_rx_byte, model_byte);
        end
        checks++;
        if (o_bcd4d !== model_bcd()) begin
            errors++;
            $display("[TB] FAIL rand_bcd got %h want %h", o_bcd4d, model_bcd());
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int v0;
        int e0;
        logic [15:0] d0;
        v0 = valid_cnt;
        e0 = err_cnt;
        d0 = model_bcd();
        send_frame(8'h31, BIT_NOM, 1'b1, 1'b1);
        #(2 * BIT_NOM);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("[TB] FAIL parity_err got %0d want 1", err_cnt - e0);
        end
        checks++;
        if (valid_cnt !== v0) begin
            errors++;
            $display("[TB] FAIL parity_no_valid got %0d want %0d", valid_cnt, v0);
        end
        checks++;
        if (o_bcd4d !== d0) begin
            errors++;
            $display("[TB] FAIL parity_bcd_held got %h want %h", o_bcd4d, d0);
        end
    endtask
`endif

    // The tests run in sequence, and the summary line is printed once at the end.
    initial begin
        $display("[TB] start");
        test_reset();
        test_back_to_back();
        test_edit();
        test_framing_error();
        test_glitch();
        test_reset_midframe();
        test_baud_tolerance();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
